ball_frame_ctrl: RTL

Per-frame controller that sequences the ball drawn by the VGA color mapper. Once per video frame it snapshots the latest GameCube pad sample and moves the ball from stick deflection with screen-edge clamping. It also resizes and recolours the ball from buttons, then commits new BallX/BallY/Ball_size/R/G/B to the mapper atomically during vertical blank.

---
 rtl/ball_frame_ctrl_if.sv | 27 ++
 rtl/ball_frame_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ball_frame_ctrl_if.sv
// Pad-sample inputs and committed ball outputs shared between the frame
// controller (slave) and whatever drives it (master).
interface ball_frame_ctrl_if;
  logic       frame_start;
  logic       pad_valid;
  logic [7:0] pad_stick_x;
  logic [7:0] pad_stick_y;
  logic [3:0] pad_buttons;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic [9:0] Ball_size;
  logic [7:0] R;
  logic [7:0] G;
  logic [7:0] B;
  logic       busy;
  logic       update_done;

  modport slave (
    input  frame_start, pad_valid, pad_stick_x, pad_stick_y, pad_buttons,
    output BallX, BallY, Ball_size, R, G, B, busy, update_done
  );

  modport master (
    output frame_start, pad_valid, pad_stick_x, pad_stick_y, pad_buttons,
    input  BallX, BallY, Ball_size, R, G, B, busy, update_done
  );
endinterface

// File: rtl/ball_frame_ctrl.sv
// Once-per-frame ball update: snapshots the pad, moves/resizes/recolours the
// ball and commits all outputs together in one edge during vertical blank.
module ball_frame_ctrl #(
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479,
  parameter int SIZE_DEF  = 4,
  parameter int SIZE_MIN  = 2,
  parameter int SIZE_MAX  = 32,
  parameter int DEAD_ZONE = 16,
  parameter int SHIFT     = 4
) (
  input logic              Clk,
  input logic              Reset,
  ball_frame_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SNAP, MOVE_X, MOVE_Y, COMMIT} state_t;

  localparam logic signed [8:0] DZ = 9'(DEAD_ZONE);

  state_t state, state_nxt;
  logic   pending, pending_nxt;

  logic [7:0] sh_x, sh_y;
  logic [3:0] sh_btn;
  logic       prev_x;
  logic [1:0] pal;

  logic signed [11:0] vx_p1, vy_p1;
  logic [9:0]         size_p1;
  logic               home_p1;
  logic [9:0]         cx_p2;
  logic [9:0]         cy_p3;

  function automatic logic signed [11:0] deflect(input logic [7:0] stick);
    logic signed [8:0] d;
    logic signed [8:0] t;
    d = $signed({1'b0, stick}) - 9'sd128;
    if (d > -DZ && d < DZ) return '0;
    t = d >>> SHIFT;
    return {{3{t[8]}}, t};
  endfunction

  // Signed 12-bit sum so a negative step near the left/top edge cannot wrap.
  function automatic logic [9:0] clamp(input logic [9:0] pos, input logic signed [11:0] v,
                                       input logic [9:0] size, input int lo_b, input int hi_b);
    logic signed [11:0] c, lo, hi;
    c  = $signed({2'b00, pos}) + v;
    lo = 12'(lo_b + int'(size));
    hi = 12'(hi_b - int'(size));
    if (c < lo)      c = lo;
    else if (c > hi) c = hi;
    return c[9:0];
  endfunction

  function automatic logic [9:0] size_step(input logic [9:0] s, input logic [3:0] btn);
    if (btn[3])           return 10'(SIZE_DEF);
    if (btn[0] && btn[1]) return s;
    if (btn[0])           return (s >= 10'(SIZE_MAX)) ? 10'(SIZE_MAX) : s + 10'd1;
    if (btn[1])           return (s <= 10'(SIZE_MIN)) ? 10'(SIZE_MIN) : s - 10'd1;
    return s;
  endfunction

  function automatic logic [23:0] palette(input logic [1:0] idx);
    case (idx)
      2'd1:    return 24'hFF0000;
      2'd2:    return 24'h00FF00;
      2'd3:    return 24'h0000FF;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    case (state)
      IDLE: begin
        if (bus.frame_start || pending) begin
          state_nxt   = SNAP;
          pending_nxt = 1'b0;
        end
      end
      SNAP:    state_nxt = MOVE_X;
      MOVE_X:  state_nxt = MOVE_Y;
      MOVE_Y:  state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && bus.frame_start) pending_nxt = 1'b1;
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state           <= IDLE;
      pending         <= 1'b0;
      sh_x            <= 8'd128;
      sh_y            <= 8'd128;
      sh_btn          <= 4'd0;
      prev_x          <= 1'b0;
      pal             <= 2'd0;
      bus.BallX       <= 10'd320;
      bus.BallY       <= 10'd240;
      bus.Ball_size   <= 10'(SIZE_DEF);
      {bus.R, bus.G, bus.B} <= 24'hFFFFFF;
      bus.update_done <= 1'b0;
    end else begin
      state           <= state_nxt;
      pending         <= pending_nxt;
      bus.update_done <= (state == COMMIT);
      if (bus.pad_valid) begin
        sh_x   <= bus.pad_stick_x;
        sh_y   <= bus.pad_stick_y;
        sh_btn <= bus.pad_buttons;
      end
      if (state == SNAP) begin
        prev_x <= sh_btn[2];
        if (sh_btn[2] && !prev_x) pal <= pal + 2'd1;
      end
      if (state == COMMIT) begin
        bus.BallX     <= cx_p2;
        bus.BallY     <= cy_p3;
        bus.Ball_size <= size_p1;
        {bus.R, bus.G, bus.B} <= palette(pal);
      end
    end
  end

  // p1: snapshot -> velocities and new size; p2/p3: clamped X then Y.
  always_ff @(posedge Clk) begin
    if (state == SNAP) begin
      vx_p1   <= deflect(sh_x);
      vy_p1   <= deflect(sh_y);
      size_p1 <= size_step(bus.Ball_size, sh_btn);
      home_p1 <= sh_btn[3];
    end
    if (state == MOVE_X)
      cx_p2 <= home_p1 ? 10'd320 : clamp(bus.BallX, vx_p1, size_p1, X_MIN, X_MAX);
    if (state == MOVE_Y)
      cy_p3 <= home_p1 ? 10'd240 : clamp(bus.BallY, vy_p1, size_p1, Y_MIN, Y_MAX);
  end
endmodule
